// File: rtl/intermitentes_scheduler.sv
// Turn-signal lamp scheduler: arbitrates hazard, lever and comfort-blink requests and drives D/I.
// Optional comfort (lane-change) sequence compiled in with `define INTERMITENTES_COMFORT_EN.
module intermitentes_scheduler #(
  parameter int unsigned TICK_DIV       = 25_000_000,
  parameter int unsigned COMFORT_BLINKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E,
  input  logic [1:0] ADI,
  output logic       clk1s,
  output logic       D,
  output logic       I,
  output logic [1:0] Status
);

  localparam int unsigned DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2 || COMFORT_BLINKS < 1) begin : g_param_check
    $error("intermitentes_scheduler: TICK_DIV must be >= 2 and COMFORT_BLINKS >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RIGHT  = 2'b01,
    ST_LEFT   = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  logic            r_e_s1, r_e_s2;
  logic [1:0]      r_adi_s1, r_adi_s2;
  state_t          r_state, w_next;
  logic [DIVW-1:0] r_div, w_div_next;
  logic            r_lit, w_lit_next;
  logic            r_d, r_i, r_clk1s;
  logic [1:0]      r_status;
  logic            w_right, w_left, w_tc, w_chg, w_release;

  assign w_right = (r_adi_s2 == 2'b01);
  assign w_left  = (r_adi_s2 == 2'b10);
  assign w_tc    = (r_div == DIVW'(TICK_DIV - 1));

`ifdef INTERMITENTES_COMFORT_EN
  localparam int unsigned NPW = $clog2(COMFORT_BLINKS + 1);
  logic [NPW-1:0] r_npulse, w_npulse_next;
  logic           r_pending, w_pending_next;
  logic           w_comfort_done;

  // Pending exit happens on the falling phase edge that closes the final guaranteed pulse.
  assign w_comfort_done = (r_npulse == NPW'(COMFORT_BLINKS)) && r_lit && w_tc;
`endif

  always_comb begin
    w_next    = r_state;
    w_release = 1'b0;
    if (r_e_s2) begin
      w_next = ST_HAZARD;
    end else begin
      case (r_state)
        ST_RIGHT: if (w_left) w_next = ST_LEFT;
                  else if (!w_right) w_release = 1'b1;
        ST_LEFT:  if (w_right) w_next = ST_RIGHT;
                  else if (!w_left) w_release = 1'b1;
        default:  if (w_right) w_next = ST_RIGHT;
                  else if (w_left) w_next = ST_LEFT;
                  else w_next = ST_IDLE;
      endcase
    end
`ifdef INTERMITENTES_COMFORT_EN
    if (w_release) begin
      if (r_pending) begin
        if (w_comfort_done) w_next = ST_IDLE;
      end else if (r_npulse >= NPW'(COMFORT_BLINKS)) begin
        w_next = ST_IDLE;
      end
    end
`else
    if (w_release) w_next = ST_IDLE;
`endif
  end

  assign w_chg = (w_next != r_state);

  always_comb begin
    w_div_next = '0;
    w_lit_next = 1'b0;
    if (w_next == ST_IDLE) begin
      w_div_next = '0;
      w_lit_next = 1'b0;
    end else if (w_chg) begin
      w_div_next = '0;
      w_lit_next = 1'b1;
    end else if (w_tc) begin
      w_div_next = '0;
      w_lit_next = ~r_lit;
    end else begin
      w_div_next = r_div + DIVW'(1);
      w_lit_next = r_lit;
    end
  end

`ifdef INTERMITENTES_COMFORT_EN
  // Pending persists only while the lever stays released and the mode is held.
  assign w_pending_next = w_release && !w_chg;

  always_comb begin
    w_npulse_next = '0;
    if (w_next == ST_RIGHT || w_next == ST_LEFT) begin
      if (w_chg)
        w_npulse_next = NPW'(1);
      else if (w_lit_next && !r_lit && r_npulse < NPW'(COMFORT_BLINKS))
        w_npulse_next = r_npulse + NPW'(1);
      else
        w_npulse_next = r_npulse;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_npulse  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_npulse  <= w_npulse_next;
      r_pending <= w_pending_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_s1   <= 1'b0;
      r_e_s2   <= 1'b0;
      r_adi_s1 <= '0;
      r_adi_s2 <= '0;
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_lit    <= 1'b0;
      r_d      <= 1'b0;
      r_i      <= 1'b0;
      r_clk1s  <= 1'b0;
      r_status <= '0;
    end else begin
      r_e_s1   <= E;
      r_e_s2   <= r_e_s1;
      r_adi_s1 <= ADI;
      r_adi_s2 <= r_adi_s1;
      r_state  <= w_next;
      r_div    <= w_div_next;
      r_lit    <= w_lit_next;
      r_d      <= w_lit_next && (w_next == ST_RIGHT || w_next == ST_HAZARD);
      r_i      <= w_lit_next && (w_next == ST_LEFT  || w_next == ST_HAZARD);
      r_clk1s  <= w_lit_next;
      r_status <= w_next;
    end
  end

  assign clk1s  = r_clk1s;
  assign D      = r_d;
  assign I      = r_i;
  assign Status = r_status;

endmodule

// File: tb/tb_intermitentes_scheduler.sv
// Directed bench for intermitentes_scheduler with TICK_DIV=4, COMFORT_BLINKS=3.
// Expectations follow the build selected by INTERMITENTES_COMFORT_EN.
module tb_intermitentes_scheduler;

  localparam int unsigned TD = 4;
  localparam int unsigned CB = 3;
`ifdef INTERMITENTES_COMFORT_EN
  localparam bit COMFORT = 1'b1;
`else
  localparam bit COMFORT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       E     = 1'b1;
  logic [1:0] ADI   = 2'b01;
  logic       clk1s, D, I;
  logic [1:0] Status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intermitentes_scheduler #(.TICK_DIV(TD), .COMFORT_BLINKS(CB)) dut (
    .clk(clk), .reset(reset), .E(E), .ADI(ADI),
    .clk1s(clk1s), .D(D), .I(I), .Status(Status)
  );

  typedef struct {
    logic [1:0] adi;
    logic       e;
    logic [1:0] st;
    logic       d;
    logic       i;
    logic       c;
  } vec_t;

  vec_t tbl[35];

  task automatic fill(input int lo, input int hi, input logic [1:0] adi, input logic e,
                      input logic [1:0] st, input logic d, input logic i, input logic c);
    for (int k = lo; k <= hi; k++) begin
      tbl[k-1].adi = adi; tbl[k-1].e = e; tbl[k-1].st = st;
      tbl[k-1].d = d; tbl[k-1].i = i; tbl[k-1].c = c;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [1:0] st,
                         input logic d, input logic i, input logic c);
    chk({tag, ".Status"}, idx, Status, st);
    chk({tag, ".D"}, idx, {1'b0, D}, {1'b0, d});
    chk({tag, ".I"}, idx, {1'b0, I}, {1'b0, i});
    chk({tag, ".clk1s"}, idx, {1'b0, clk1s}, {1'b0, c});
  endtask

  task automatic step(input logic [1:0] adi, input logic e);
    ADI = adi;
    E   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ADI   = 2'b00;
    E     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("rst", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  function automatic logic in_r(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  initial begin
    fill( 1,  2, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    fill( 3,  6, 2'b01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    fill( 7, 10, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    fill(11, 14, 2'b01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    fill(15, 16, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    fill(17, 20, 2'b10, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
    fill(21, 21, 2'b10, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    fill(22, 23, 2'b10, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    fill(24, 27, 2'b10, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    fill(28, 28, 2'b10, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    fill(29, 30, 2'b10, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    fill(31, 34, 2'b10, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1);
    fill(35, 35, 2'b10, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

    // Reset held with active requests: outputs stay cleared.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Right blink, reversal to left, hazard mid-off-phase, hazard release.
    for (int k = 0; k < 35; k++) begin
      step(tbl[k].adi, tbl[k].e);
      chk_all("table", k + 1, tbl[k].st, tbl[k].d, tbl[k].i, tbl[k].c);
    end

    // Hazard and lever asserted together: hazard wins.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(2'b01, 1'b1);
      chk_all("simul", k, (k == 3) ? 2'd3 : 2'd0, k == 3, k == 3, k == 3);
    end

    // Short tap of right lever for 6 cycles.
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      logic ed;
      logic [1:0] es;
      step((k <= 6) ? 2'b01 : 2'b00, 1'b0);
      ed = COMFORT ? (in_r(k, 3, 6) || in_r(k, 11, 14) || in_r(k, 19, 22)) : in_r(k, 3, 6);
      es = (COMFORT ? in_r(k, 3, 22) : in_r(k, 3, 8)) ? 2'd1 : 2'd0;
      chk("tap.Status", k, Status, es);
      chk("tap.D", k, {1'b0, D}, {1'b0, ed});
    end

    // Lever held through the fourth pulse, then released mid on-phase.
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      logic ed;
      step((k <= 27) ? 2'b01 : 2'b00, 1'b0);
      ed = in_r(k, 3, 6) || in_r(k, 11, 14) || in_r(k, 19, 22) || in_r(k, 27, 29);
      chk("held.Status", k, Status, in_r(k, 3, 29) ? 2'd1 : 2'd0);
      chk("held.D", k, {1'b0, D}, {1'b0, ed});
    end

    // Pending comfort cancelled by reversal, then invalid lever code acts as release.
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      logic [1:0] adi, es;
      logic ed, ei;
      adi = (k <= 6) ? 2'b01 : (k <= 11) ? 2'b00 : (k <= 18) ? 2'b10 : 2'b11;
      step(adi, 1'b0);
      if (COMFORT) begin
        es = in_r(k, 3, 13) ? 2'd1 : in_r(k, 14, 33) ? 2'd2 : 2'd0;
        ed = in_r(k, 3, 6) || in_r(k, 11, 13);
        ei = in_r(k, 14, 17) || in_r(k, 22, 25) || in_r(k, 30, 33);
      end else begin
        es = in_r(k, 3, 8) ? 2'd1 : in_r(k, 14, 20) ? 2'd2 : 2'd0;
        ed = in_r(k, 3, 6);
        ei = in_r(k, 14, 17);
      end
      chk_all("cancel", k, es, ed, ei, ed | ei);
    end

    // Short asynchronous reset pulse mid on-phase, then no blink while lever is off.
    do_reset();
    for (int k = 1; k <= 4; k++) step(2'b01, 1'b0);
    chk_all("pre_async", 4, 2'd1, 1'b1, 1'b0, 1'b1);
    #3;
    reset = 1'b0;
    ADI   = 2'b00;
    #1;
    chk_all("async_rst", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(2'b00, 1'b0);
      chk_all("post_rst", k, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intermitentes_scheduler.md
# intermitentes_scheduler

Turn-signal lamp scheduler for the 50 MHz board. It arbitrates the lamp pair between three requesters: the hazard switch `E`, the direction lever `ADI`, and an optional comfort-blink (lane-change) sequence. It generates the blink phase internally and drives the right/left lamp outputs, `D` and `I`. It sits between the synchronised switch inputs and the lamp drivers, and replaces ad-hoc blink logic in the top level.

## Interface
- `TICK_DIV`, default 25_000_000: clk cycles per blink half-period (0.5 s on, 0.5 s off). Must be ≥2.
- `COMFORT_BLINKS`, default 3: number of on-pulses guaranteed after a short lever tap.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `E`  in  1  hazard request, asynchronous switch.
- `ADI`  in  2  lever: 00 off, 01 right, 10 left, 11 invalid (treated as 00).
- `clk1s`  out  1  blink phase (1 = lamps lit); 0 in IDLE.
- `D`  out  1  right lamp.
- `I`  out  1  left lamp.
- `Status`  out  2  current state: 00 IDLE, 01 RIGHT, 10 LEFT, 11 HAZARD.

## Operation
- `E` and `ADI` each pass through a 2-flop synchroniser (reset value 0) before any use.
- States and transitions, with priority HAZARD > lever > comfort > IDLE:
  - Any state → HAZARD when `E`=1.
  - HAZARD → RIGHT/LEFT/IDLE per lever when `E`=0.
  - IDLE → RIGHT on 01, LEFT on 10.
  - RIGHT ↔ LEFT immediately when the lever reverses. This also cancels any pending comfort sequence.
  - RIGHT/LEFT → IDLE on lever 00 or 11, subject to the comfort rule.
- Phase generator:
  - Counter `div` runs 0..TICK_DIV-1. Register `lit` toggles when `div` reaches its terminal count.
  - On every state change, `div` is cleared and `lit` is forced to 1. Each new mode therefore starts lit, with a full half-period.
  - In IDLE, `div`=0 and `lit`=0.
- Pulse counter `npulse`:
  - Width is clog2(COMFORT_BLINKS+1) and the counter saturates at COMFORT_BLINKS.
  - Set to 1 on entry to RIGHT/LEFT and incremented on each 0→1 of `lit`.
  - Cleared in IDLE and HAZARD.
- Outputs:
  - `D` = `lit` & (RIGHT|HAZARD).
  - `I` = `lit` & (LEFT|HAZARD).
  - `clk1s` = `lit`.
  - `Status` = state.
  - All outputs are registers, loaded from next-state values on the same edge as the state update. No combinational glitches.
- Comfort rule (macro-enabled only):
  - If the lever releases to 00/11 while `npulse` < COMFORT_BLINKS, stay in RIGHT/LEFT. Go to IDLE at the 1→0 of `lit` that ends on-pulse number COMFORT_BLINKS.
  - If `npulse` ≥ COMFORT_BLINKS at release, go to IDLE immediately.
  - Re-pressing the same direction during the pending sequence keeps the current phase (no restart).

## Timing
- Reset values: all outputs 0, state IDLE, `div`=0, `lit`=0, `npulse`=0, synchronisers 0. Reset is asynchronous: outputs clear without waiting for `clk`.
- Input latency: an input stable before edge k appears in `Status`/`D`/`I` after edge k+2.
- Blink waveform: on entry, `lit`=1 for exactly TICK_DIV cycles, then 0 for TICK_DIV cycles, repeating.
- Simultaneous events: if `E` rises on the same edge as a lever change, HAZARD wins. If `E` falls on the same edge the lever reverses, the new direction is entered lit.
- A phase terminal count on the same edge as a state change is ignored; the phase restarts.
- Reset asserted mid-sequence aborts comfort. After reset release there is no blink until the lever or `E` is asserted again.

## Configuration
- `INTERMITENTES_COMFORT_EN` defined: comfort rule and `npulse` are compiled in.
- Not defined: `npulse` and its logic are removed, and lever release to 00/11 goes to IDLE immediately.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use TICK_DIV=4 and COMFORT_BLINKS=3.
- Reset low with ADI=01 and E=1 → all outputs 0. Release reset, hold ADI=01 → after edge 3: `Status`=01, `D`=1. `D` toggles every 4 cycles, `I`=0 throughout.
- ADI=10 blinking, then E=1 mid-off-phase → after 3 edges: `Status`=11, `D`=`I`=1, same waveform. Set E=0 → `Status`=10, `I`=1 for a fresh 4 cycles.
- Macro defined: ADI=01 for 6 cycles, then 00 → exactly 3 `D` pulses of 4 cycles each. `Status`=00 on the edge `D` falls the 3rd time.
- Macro defined: ADI=01 held through 4 pulses, then 00 → `Status`=00 and `D`=0 after 3 edges. Without the macro, the tap from the previous scenario gives 1 pulse and then IDLE.
- Comfort pending after release of 01, then ADI=10 → `Status`=10 immediately, `D`=0, `I`=1 restart. ADI=11 → behaves as 00.
- Reset driven low for 1 ns mid-on-phase, not aligned to `clk` → `D`/`I`/`clk1s`/`Status` are 0 before the next `clk` edge.
